// File: rtl/lfsr_checker_pkg.sv
// =============================================================================
// lfsr_checker_pkg : state encodings, LFSR tap mask and default lock thresholds
// Revision: 1.0
// =============================================================================
`default_nettype none

package lfsr_checker_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_BAD    = 2'd3
  } state_e;

  // Feedback taps for x^4 + x^3 + 1, i.e. bits [3] and [2] of the current word
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_LOSS_COUNT = 3;

endpackage

`default_nettype wire

// File: rtl/lfsr_checker_step.sv
// =============================================================================
// lfsr4_step : combinational next-word function of the 4-bit LFSR
// Revision: 1.0
// =============================================================================
`default_nettype none

module lfsr4_step
  import lfsr_checker_pkg::*;
(
  input  logic [3:0] cur,
  output logic [3:0] nxt
);

  assign nxt = {cur[2:0], ^(cur & LFSR_TAPS)};

endmodule

`default_nettype wire

// File: rtl/lfsr_checker.sv
// =============================================================================
// lfsr_checker : hunts, verifies and tracks a 4-bit LFSR stream, counting
//                mismatches while synchronised. Revision: 1.0
// =============================================================================
`default_nettype none

module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned LOSS_COUNT = DEF_LOSS_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [3:0] sample,
  input  logic       clr_errs,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic [1:0] state_dbg
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  LOSS_TGT = MISS_W'(LOSS_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [MISS_W-1:0]  MISS_ONE  = MISS_W'(1);

  state_e               state_q, state_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [3:0]           expected_q, expected_d;
  logic [7:0]           err_count_q, err_count_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 locked_q, locked_d;

  logic [3:0]           step_sample;
  logic [3:0]           step_fly;
  logic [MATCH_W-1:0]   match_inc;
  logic [MISS_W-1:0]    miss_inc;
  logic                 hit;

  lfsr4_step u_step_sample (
    .cur (sample),
    .nxt (step_sample)
  );

  lfsr4_step u_step_fly (
    .cur (expected_q),
    .nxt (step_fly)
  );

  assign match_inc = match_q + MATCH_ONE;
  assign miss_inc  = miss_q + MISS_ONE;
  assign hit       = (sample == expected_q);

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    miss_d      = miss_q;
    expected_d  = expected_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (state_q == ST_BAD) begin
      state_d = ST_HUNT;
      match_d = '0;
      miss_d  = '0;
    end else if (sample_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (sample != 4'b0000) begin
            expected_d = step_sample;
            match_d    = MATCH_ONE;
            if (MATCH_ONE >= LOCK_TGT) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end

        ST_VERIFY: begin
          if (hit) begin
            expected_d = step_sample;
            match_d    = match_inc;
            if (match_inc >= LOCK_TGT) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (sample != 4'b0000) begin
            expected_d = step_sample;
            match_d    = MATCH_ONE;
          end else begin
            state_d = ST_HUNT;
            match_d = '0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: once locked the expected word never follows the input
          expected_d = step_fly;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
            if (miss_inc >= LOSS_TGT) begin
              state_d = ST_HUNT;
              miss_d  = '0;
              match_d = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    if (clr_errs) begin
      err_count_d = 8'd0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HUNT;
      match_q     <= '0;
      miss_q      <= '0;
      expected_q  <= 4'b0001;
      err_count_q <= 8'd0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state_dbg = state_q;

endmodule

`default_nettype wire

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: number of consecutive consistent samples needed to declare lock (seed sample included).
REQ-002 SHALL have parameter LOSS_COUNT, default 3: number of consecutive mismatches while locked that declares loss of lock.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sample_valid, input, 1: qualifies sample for one clk cycle.
REQ-006 SHALL have port sample, input, 4: received 4-bit LFSR word.
REQ-007 SHALL have port clr_errs, input, 1: synchronous clear of err_count.
REQ-008 SHALL have port locked, output, 1: checker is synchronised to the sequence.
REQ-009 SHALL have port err_pulse, output, 1: one-cycle strobe per mismatched sample while locked.
REQ-010 SHALL have port err_count, output, 8: saturating count of locked-state mismatches.
REQ-011 SHALL have port state_dbg, output, 2: current FSM state encoding.

Function
REQ-012 SHALL use the sequence rule next(q) = {q[2:0], q[3]^q[2]} (x^4+x^3+1, period 15, 0000 illegal).
REQ-013 SHALL act only on cycles with sample_valid=1; with sample_valid=0, state, counters and expected word SHALL hold and err_pulse SHALL be 0.
REQ-014 SHALL implement FSM states HUNT=0, VERIFY=1, LOCKED=2; encoding 3 unused and SHALL recover to HUNT.
REQ-015 In HUNT, a valid nonzero sample SHALL set expected=next(sample), match count=1, and go to VERIFY; a valid 0000 SHALL be ignored.
REQ-016 In VERIFY, sample==expected SHALL increment match count and set expected=next(sample); when the count reaches LOCK_COUNT the FSM SHALL go to LOCKED with miss count=0.
REQ-017 In VERIFY, a mismatch with a nonzero sample SHALL reseed (expected=next(sample), match count=1, stay VERIFY); a 0000 sample SHALL return to HUNT.
REQ-018 In LOCKED, a match SHALL clear miss count; expected SHALL always advance as expected=next(expected) (flywheel, never reseeded from sample).
REQ-019 In LOCKED, a mismatch (including 0000) SHALL assert err_pulse, increment err_count, and increment miss count; reaching LOSS_COUNT consecutive misses SHALL go to HUNT.
REQ-020 All outputs SHALL be registered: effects of a sample appear on the cycle after the edge that samples it; locked SHALL equal (state==LOCKED).
REQ-021 err_count SHALL saturate at 255 and never wrap.
REQ-022 clr_errs SHALL set err_count to 0 on the next edge and SHALL take priority over a simultaneous increment; err_pulse still fires.
REQ-023 Errors SHALL be counted only in LOCKED; VERIFY mismatches SHALL NOT touch err_count or err_pulse.

Reset
REQ-024 Assertion of reset (low) SHALL immediately force state=HUNT, locked=0, err_pulse=0, err_count=0, match/miss counts=0, expected=0001, regardless of clk, including mid-sequence.
REQ-025 The first edge after reset deassertion SHALL behave as a normal HUNT cycle.

Structure
REQ-026 A shared package SHALL hold the state encodings, the tap constant (x^4+x^3+1) and the default LOCK_COUNT/LOSS_COUNT values.
REQ-027 The next-state function SHALL be a combinational sub-module lfsr4_step, shared with the generator side, instantiated twice (sample path and flywheel path).
REQ-028 Match and miss counters SHALL be sized to hold LOCK_COUNT and LOSS_COUNT respectively.

Verification
REQ-029 Lock: after reset, valid samples 0001,0010,0100,1001 -> locked=1 on the cycle after 1001; err_count=0.
REQ-030 Single error: locked at 1001, next samples 0011,0111(bad),1101 -> one err_pulse, err_count=1, locked stays 1 (flywheel expected 0110 then 1101).
REQ-031 Loss: locked, three consecutive wrong samples -> err_count=3, locked=0 after third; then 1010,0101,1011,0111 -> relock.
REQ-032 Zero/reseed: in HUNT feed 0000 (ignored), then 0001,0100 (reseed),1001,0011,0110 -> locked after 0110.
REQ-033 Saturation and clear: force 300 locked mismatches -> err_count=255; clr_errs coincident with a mismatch -> err_count=0, err_pulse=1.
REQ-034 Async reset: assert reset mid-LOCKED between clk edges -> locked=0, err_count=0 before the next edge; gaps in sample_valid hold all state.
